qdr_req_sequencer: RTL and testbench

- User-side front end for one QDR controller instance, sitting directly upstream of the controller's usr_* port group.
- Accepts tagged read/write requests on a valid/ready stream and holds requests off until calibration completes.
- Issues at most one command per cycle and limits outstanding reads with credits.
- Pairs returned read data with the original request tags and buffers the results in a response FIFO with backpressure.

---
 rtl/qdr_req_sequencer.sv | 162 ++++++++++++++++
 tb/tb_qdr_req_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdr_req_sequencer.sv
// User-side request sequencer for one QDR controller: gates requests on calibration,
// issues registered commands, meters reads with credits and re-tags returned read data.
module qdr_req_sequencer #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 72,
    parameter int BE_WIDTH   = 8,
    parameter int TAG_WIDTH  = 8,
    parameter int MAX_OUT    = 16
) (
    input  logic                       clk0,
    input  logic                       reset,
    input  logic                       phy_rdy,
    input  logic                       cal_fail,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic [BE_WIDTH-1:0]        req_be,
    input  logic [TAG_WIDTH-1:0]       req_tag,
    output logic [ADDR_WIDTH-1:0]      usr_addr,
    output logic                       usr_wr_strb,
    output logic [DATA_WIDTH-1:0]      usr_wr_data,
    output logic [BE_WIDTH-1:0]        usr_wr_be,
    output logic                       usr_rd_strb,
    input  logic [DATA_WIDTH-1:0]      usr_rd_data,
    input  logic                       usr_rd_dvld,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [TAG_WIDTH-1:0]       rsp_tag,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       err_fail,
    output logic                       err_unexp
);

    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam int RW = TAG_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        WAIT_CAL = 2'd0,
        RUN      = 2'd1,
        FAIL     = 2'd2
    } state_t;

    state_t state;

    logic credit_avail;
    logic accept;
    logic accept_rd;
    logic accept_wr;

    logic [TAG_WIDTH-1:0] tag_mem [MAX_OUT];
    logic [PW:0]          tag_wp;
    logic [PW:0]          tag_rp;
    logic                 tag_empty;
    logic                 tag_pop;

    logic [RW-1:0]        rsp_mem [MAX_OUT];
    logic [PW:0]          rsp_wp;
    logic [PW:0]          rsp_rp;
    logic                 rsp_empty;
    logic                 rsp_pop;
    logic [RW-1:0]        rsp_head;

    assign credit_avail = (outstanding < CW'(MAX_OUT));
    assign req_ready    = (state == RUN) && credit_avail;
    assign accept       = req_valid && req_ready;
    assign accept_rd    = accept && !req_we;
    assign accept_wr    = accept && req_we;

    // Pointers carry one extra bit so full and empty differ when the indices match.
    assign tag_empty = (tag_wp == tag_rp);
    assign tag_pop   = usr_rd_dvld && !tag_empty;

    assign rsp_empty = (rsp_wp == rsp_rp);
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_head  = rsp_valid ? rsp_mem[rsp_rp[PW-1:0]] : '0;
    assign rsp_tag   = rsp_head[RW-1:DATA_WIDTH];
    assign rsp_data  = rsp_head[DATA_WIDTH-1:0];

    // Storage arrays need no reset; emptiness is tracked purely by the pointers.
    always_ff @(posedge clk0) begin
        if (accept_rd) begin
            tag_mem[tag_wp[PW-1:0]] <= req_tag;
        end
        if (tag_pop) begin
            rsp_mem[rsp_wp[PW-1:0]] <= {tag_mem[tag_rp[PW-1:0]], usr_rd_data};
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state       <= WAIT_CAL;
            usr_wr_strb <= 1'b0;
            usr_rd_strb <= 1'b0;
            usr_addr    <= '0;
            usr_wr_data <= '0;
            usr_wr_be   <= '0;
            outstanding <= '0;
            err_fail    <= 1'b0;
            err_unexp   <= 1'b0;
            tag_wp      <= '0;
            tag_rp      <= '0;
            rsp_wp      <= '0;
            rsp_rp      <= '0;
        end else begin
            case (state)
                WAIT_CAL: begin
                    if (cal_fail) begin
                        state <= FAIL;
                    end else if (phy_rdy) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cal_fail) begin
                        state <= FAIL;
                    end else if (!phy_rdy) begin
                        state <= WAIT_CAL;
                    end
                end
                default: state <= FAIL;
            endcase

            if (cal_fail) begin
                err_fail <= 1'b1;
            end

            usr_wr_strb <= accept_wr;
            usr_rd_strb <= accept_rd;
            if (accept) begin
                usr_addr <= req_addr;
            end
            if (accept_wr) begin
                usr_wr_data <= req_data;
                usr_wr_be   <= req_be;
            end

            // Credits are held from read accept until the response leaves the FIFO.
            outstanding <= outstanding + CW'(accept_rd) - CW'(rsp_pop);

            if (accept_rd) begin
                tag_wp <= tag_wp + 1'b1;
            end
            if (tag_pop) begin
                tag_rp <= tag_rp + 1'b1;
                rsp_wp <= rsp_wp + 1'b1;
            end
            if (rsp_pop) begin
                rsp_rp <= rsp_rp + 1'b1;
            end

            if (usr_rd_dvld && tag_empty) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qdr_req_sequencer.sv
// Scoreboard bench for qdr_req_sequencer: directed requests, a fixed-latency controller
// model, and a negedge monitor that checks commands and responses against queued expectations.
module tb_qdr_req_sequencer;

    localparam int AW = 21;
    localparam int DW = 72;
    localparam int BW = 8;
    localparam int TW = 8;
    localparam int MO = 16;
    localparam int CW = 5;
    localparam int RD_LAT = 10;

    logic          clk0 = 1'b0;
    logic          reset = 1'b1;
    logic          phy_rdy = 1'b0;
    logic          cal_fail = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic [BW-1:0] req_be = '0;
    logic [TW-1:0] req_tag = '0;
    logic [AW-1:0] usr_addr;
    logic          usr_wr_strb;
    logic [DW-1:0] usr_wr_data;
    logic [BW-1:0] usr_wr_be;
    logic          usr_rd_strb;
    logic [DW-1:0] usr_rd_data = '0;
    logic          usr_rd_dvld = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic [CW-1:0] outstanding;
    logic          err_fail;
    logic          err_unexp;

    qdr_req_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_WIDTH(TW), .MAX_OUT(MO)
    ) dut (
        .clk0(clk0), .reset(reset), .phy_rdy(phy_rdy), .cal_fail(cal_fail),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be), .req_tag(req_tag),
        .usr_addr(usr_addr), .usr_wr_strb(usr_wr_strb), .usr_wr_data(usr_wr_data),
        .usr_wr_be(usr_wr_be), .usr_rd_strb(usr_rd_strb), .usr_rd_data(usr_rd_data),
        .usr_rd_dvld(usr_rd_dvld), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .outstanding(outstanding),
        .err_fail(err_fail), .err_unexp(err_unexp)
    );

    always #5 clk0 = ~clk0;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        int            due;
    } cmd_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } ret_t;

    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];
    ret_t ctrl_q[$];
    int   cyc = 0;
    bit   inject_dvld = 1'b0;
    int   checks = 0;
    int   passes = 0;

    function automatic logic [DW-1:0] rd_data_for(logic [AW-1:0] a);
        return {a, 30'h2AAAAAAA, ~a};
    endfunction

    task automatic check_output(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    always @(posedge clk0) cyc++;

    // Controller model: each read strobe returns rd_data_for(addr) RD_LAT cycles later, in order.
    always @(posedge clk0) begin : ctrl_drv
        ret_t t;
        #1;
        if (ctrl_q.size() > 0 && cyc >= ctrl_q[0].due) begin
            t = ctrl_q.pop_front();
            usr_rd_dvld = 1'b1;
            usr_rd_data = rd_data_for(t.addr);
        end else if (inject_dvld) begin
            usr_rd_dvld = 1'b1;
            usr_rd_data = '1;
            inject_dvld = 1'b0;
        end else begin
            usr_rd_dvld = 1'b0;
        end
    end

    always @(negedge clk0) begin : monitor
        cmd_t e;
        rsp_t r;
        if (usr_wr_strb || usr_rd_strb) begin
            if (exp_cmd_q.size() == 0) begin
                check_output("unexpected strobe", 1, 0);
            end else begin
                e = exp_cmd_q.pop_front();
                check_output("cmd latency", cyc, e.due);
                check_output("usr_wr_strb", usr_wr_strb, e.we);
                check_output("usr_rd_strb", usr_rd_strb, !e.we);
                check_output("usr_addr", usr_addr, e.addr);
                if (e.we) begin
                    check_output("usr_wr_data", usr_wr_data, e.data);
                    check_output("usr_wr_be", usr_wr_be, e.be);
                end
            end
            if (usr_rd_strb) begin
                ctrl_q.push_back('{cyc + RD_LAT, usr_addr});
            end
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
                check_output("unexpected response", 1, 0);
            end else begin
                r = exp_rsp_q.pop_front();
                check_output("rsp_tag", rsp_tag, r.tag);
                check_output("rsp_data", rsp_data, r.data);
            end
        end
    end

    task automatic apply_stimulus(input bit we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] data, input logic [BW-1:0] be,
                                  input logic [TW-1:0] tag, output int tries);
        bit done;
        done = 1'b0;
        tries = 0;
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_data = data;
        req_be = be;
        req_tag = tag;
        while (!done && tries < 50) begin
            tries++;
            @(negedge clk0);
            if (req_ready) begin
                if (we) begin
                    exp_cmd_q.push_back('{1'b1, addr, data, be, cyc + 1});
                end else begin
                    exp_cmd_q.push_back('{1'b0, addr, '0, '0, cyc + 1});
                    exp_rsp_q.push_back('{tag, rd_data_for(addr)});
                end
                done = 1'b1;
            end
            tick();
        end
        if (!done) check_output("accept timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_cmd_q.size() + exp_rsp_q.size() + ctrl_q.size()) != 0 && n < 300) begin
            tick();
            n++;
        end
        check_output("drain", exp_cmd_q.size() + exp_rsp_q.size() + ctrl_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stim
        int tries;
        bit seen;

        repeat (3) tick();
        @(negedge clk0);
        check_output("reset flags", {req_ready, usr_wr_strb, usr_rd_strb, rsp_valid, err_fail, err_unexp}, 0);
        check_output("reset usr_addr", usr_addr, 0);
        check_output("reset usr_wr_data", {usr_wr_data, usr_wr_be}, 0);
        check_output("reset rsp", {rsp_tag, rsp_data}, 0);
        check_output("reset outstanding", outstanding, 0);
        tick();
        reset = 1'b0;

        // Calibration gating with a pending write held on the request port.
        req_valid = 1'b1;
        req_we = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk0);
            if (req_ready) seen = 1'b1;
            tick();
        end
        check_output("req_ready gated", seen, 0);
        phy_rdy = 1'b1;
        apply_stimulus(1'b1, 21'h1ABCD, 72'h0123456789ABCDEF01, 8'hF0, 8'h00, tries);
        check_output("first accept tries", tries, 2);
        repeat (3) tick();
        @(negedge clk0);
        check_output("outstanding after write", outstanding, 0);
        tick();

        // In-order reads with tags.
        rsp_ready = 1'b1;
        apply_stimulus(1'b0, 21'h00010, '0, '0, 8'd3, tries);
        apply_stimulus(1'b0, 21'h00020, '0, '0, 8'd7, tries);
        apply_stimulus(1'b0, 21'h00030, '0, '0, 8'd9, tries);
        wait_drain();
        @(negedge clk0);
        check_output("outstanding after reads", outstanding, 0);
        tick();

        // Credit limit with the consumer stalled.
        rsp_ready = 1'b0;
        for (int i = 0; i < MO; i++) begin
            apply_stimulus(1'b0, AW'(32'h100 + i), '0, '0, TW'(16 + i), tries);
        end
        @(negedge clk0);
        check_output("req_ready at credit limit", req_ready, 0);
        check_output("outstanding full", outstanding, MO);
        tick();
        repeat (20) tick();
        @(negedge clk0);
        check_output("buffered rsp_valid", rsp_valid, 1);
        check_output("req_ready still blocked", req_ready, 0);
        check_output("no err_unexp", err_unexp, 0);
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge clk0);
        check_output("outstanding after pop", outstanding, MO - 1);
        check_output("req_ready after pop", req_ready, 1);
        tick();
        apply_stimulus(1'b0, 21'h00200, '0, '0, 8'd99, tries);
        check_output("refill tries", tries, 1);
        @(negedge clk0);
        check_output("req_ready refilled", req_ready, 0);
        tick();
        rsp_ready = 1'b1;
        wait_drain();
        @(negedge clk0);
        check_output("outstanding drained", outstanding, 0);
        tick();

        // Unexpected return data, then calibration failure.
        inject_dvld = 1'b1;
        repeat (3) tick();
        @(negedge clk0);
        check_output("err_unexp set", err_unexp, 1);
        check_output("rsp_valid after unexp", rsp_valid, 0);
        check_output("outstanding after unexp", outstanding, 0);
        tick();
        cal_fail = 1'b1;
        tick();
        cal_fail = 1'b0;
        req_valid = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk0);
            if (req_ready) seen = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        check_output("err_fail set", err_fail, 1);
        check_output("req_ready in FAIL", seen, 0);

        // Recover, then reset with reads in flight.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, AW'(32'h300 + i), '0, '0, TW'(40 + i), tries);
        end
        @(negedge clk0);
        check_output("outstanding before reset", outstanding, 4);
        tick();
        ctrl_q.delete();
        exp_rsp_q.delete();
        reset = 1'b1;
        tick();
        @(negedge clk0);
        check_output("midreset flags", {req_ready, usr_wr_strb, usr_rd_strb, rsp_valid, err_fail, err_unexp}, 0);
        check_output("midreset usr_addr", usr_addr, 0);
        check_output("midreset outstanding", outstanding, 0);
        check_output("midreset wr bus", {usr_wr_data, usr_wr_be}, 0);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        @(negedge clk0);
        check_output("post reset rsp_valid", rsp_valid, 0);
        check_output("post reset err_unexp", err_unexp, 0);
        check_output("post reset queues", exp_cmd_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
